// File: rtl/pipe_delay_line_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_delay_line_if
// Purpose  : Bus bundle for pipe_delay_line (input beat, control, outputs).
// Revision : 1.0
// ============================================================================
interface pipe_delay_line_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             advance;
  logic             flush;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             tap_valid;
  logic [WIDTH-1:0] tap_data;
  logic [5:0]       occupancy;

  modport master (
    output in_valid, in_data, advance, flush,
    input  out_valid, out_data, tap_valid, tap_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, advance, flush,
    output out_valid, out_data, tap_valid, tap_data, occupancy
  );
endinterface
`default_nettype wire

// File: rtl/pipe_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : pipe_delay_line
// Purpose  : DEPTH-stage stallable, flushable delay line with a mid-point tap.
//            Tap outputs are live only when PIPE_DELAY_LINE_TAP_EN is defined.
// Revision : 1.0
// ============================================================================
module pipe_delay_line #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 10,
  parameter int TAP   = 5
) (
  input  wire logic         clock,
  input  wire logic         resetn,
  pipe_delay_line_if.slave  bus
);

`ifdef PIPE_DELAY_LINE_TAP_EN
  localparam bit C_TAP_EN = 1'b1;
`else
  localparam bit C_TAP_EN = 1'b0;
`endif

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [5:0]       r_occupancy;
  logic [DEPTH-1:0] w_valid_shift;
  logic [5:0]       w_occ_next;

  generate
    if (DEPTH == 1) begin : g_single
      assign w_valid_shift = bus.in_valid;
    end else begin : g_multi
      assign w_valid_shift = {r_valid[DEPTH-2:0], bus.in_valid};
    end
  endgenerate

  // Counter tracks entries leaving and arriving instead of a popcount tree.
  always_comb begin
    w_occ_next = r_occupancy + {5'd0, bus.in_valid} - {5'd0, r_valid[DEPTH-1]};
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_data[k] <= '0;
      end
      r_valid     <= '0;
      r_occupancy <= '0;
    end else begin
      // Data moves with advance even under flush; only valid bits are killed.
      if (bus.advance) begin
        r_data[0] <= bus.in_data;
        for (int k = 1; k < DEPTH; k++) begin
          r_data[k] <= r_data[k-1];
        end
      end
      if (bus.flush) begin
        r_valid     <= '0;
        r_occupancy <= '0;
      end else if (bus.advance) begin
        r_valid     <= w_valid_shift;
        r_occupancy <= w_occ_next;
      end
    end
  end

  assign bus.out_valid = r_valid[DEPTH-1];
  assign bus.out_data  = r_data[DEPTH-1];
  assign bus.occupancy = r_occupancy;
  assign bus.tap_valid = C_TAP_EN & r_valid[TAP-1];
  assign bus.tap_data  = C_TAP_EN ? r_data[TAP-1] : '0;

endmodule
`default_nettype wire

// File: tb/tb_pipe_delay_line.sv
`default_nettype none
// Testbench for pipe_delay_line: history-based reference model plus directed
// literal scenarios and randomized traffic.
module tb_pipe_delay_line;

  localparam int WIDTH = 32;
  localparam int DEPTH = 10;
  localparam int TAP   = 5;
  localparam int HSIZE = 8192;
`ifdef PIPE_DELAY_LINE_TAP_EN
  localparam bit TAP_ON = 1'b1;
`else
  localparam bit TAP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  pipe_delay_line_if #(.WIDTH(WIDTH)) bus ();

  pipe_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAP(TAP)) dut (
    .clock  (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model: every advance appends the offered beat to a history; stage k
  // shows the entry k advances old. A flush kills every entry recorded so far.
  logic             hist_v [HSIZE];
  logic [WIDTH-1:0] hist_d [HSIZE];
  int adv_cnt    = 0;
  int kill_below = 0;

  always @(posedge clk) begin
    if (!resetn) begin
      adv_cnt    = 0;
      kill_below = 0;
    end else begin
      if (bus.advance) begin
        hist_v[adv_cnt % HSIZE] = bus.in_valid;
        hist_d[adv_cnt % HSIZE] = bus.in_data;
        adv_cnt++;
      end
      if (bus.flush) kill_below = adv_cnt;
    end
  end

  function automatic logic [WIDTH:0] stage(int k);
    int idx = adv_cnt - k;
    if (idx < 0) return '0;
    return {hist_v[idx % HSIZE] && (idx >= kill_below), hist_d[idx % HSIZE]};
  endfunction

  function automatic logic [5:0] model_occ();
    int n = 0;
    for (int k = 1; k <= DEPTH; k++) n += int'(stage(k)[WIDTH]);
    return 6'(n);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [WIDTH:0] o, t;
      o = stage(DEPTH);
      t = TAP_ON ? stage(TAP) : '0;
      check("m_out_valid", 64'(bus.out_valid), 64'(o[WIDTH]));
      check("m_out_data",  64'(bus.out_data),  64'(o[WIDTH-1:0]));
      check("m_tap_valid", 64'(bus.tap_valid), 64'(t[WIDTH]));
      check("m_tap_data",  64'(bus.tap_data),  64'(t[WIDTH-1:0]));
      check("m_occupancy", 64'(bus.occupancy), 64'(model_occ()));
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.advance  = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
  endtask

  initial begin
    idle_inputs();
    resetn = 1'b0;
    cyc();
    cyc();
    resetn = 1'b1;
    chk_en = 1'b1;

    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
    check("rst_tap_valid", 64'(bus.tap_valid), 64'd0);
    check("rst_tap_data",  64'(bus.tap_data),  64'd0);
    check("rst_occ",       64'(bus.occupancy), 64'd0);

    // Single beat through the line.
    bus.in_valid = 1'b1; bus.in_data = 32'hDEADBEEF; bus.advance = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      bus.in_valid = 1'b0; bus.in_data = $urandom;
      check("one_tap_valid", 64'(bus.tap_valid), 64'(TAP_ON && c == 5));
      if (c == 5 && TAP_ON) check("one_tap_data", 64'(bus.tap_data), 64'hDEADBEEF);
      check("one_out_valid", 64'(bus.out_valid), 64'(c == 10));
      if (c == 10) check("one_out_data", 64'(bus.out_data), 64'hDEADBEEF);
      check("one_occ", 64'(bus.occupancy), (c <= 10) ? 64'd1 : 64'd0);
    end

    // Continuous stream 1..20.
    do_reset();
    bus.advance = 1'b1;
    for (int c = 0; c < 30; c++) begin
      bus.in_valid = (c < 20);
      bus.in_data  = 32'(c + 1);
      cyc();
      if (c + 1 >= 10 && c + 1 <= 29) begin
        check("str_out_valid", 64'(bus.out_valid), 64'd1);
        check("str_out_data",  64'(bus.out_data),  64'(c + 1 - 9));
      end
      if (c + 1 <= 20)
        check("str_occ", 64'(bus.occupancy), 64'((c + 1 < 10) ? c + 1 : 10));
    end

    // Stall mid-flight.
    do_reset();
    for (int c = 0; c < 14; c++) begin
      bus.in_valid = (c < 4);
      bus.in_data  = 32'(c + 1);
      bus.advance  = !(c >= 4 && c <= 6);
      cyc();
      if (c + 1 >= 4 && c + 1 <= 7) check("stall_occ", 64'(bus.occupancy), 64'd4);
      if (c + 1 == 12) check("stall_out_early", 64'(bus.out_valid), 64'd0);
      if (c + 1 == 13) begin
        check("stall_out_valid", 64'(bus.out_valid), 64'd1);
        check("stall_out_data",  64'(bus.out_data),  64'd1);
      end
    end

    // Flush with six beats in flight.
    do_reset();
    bus.advance = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.in_valid = 1'b1; bus.in_data = 32'h11 + 32'(c);
      cyc();
    end
    check("pre_flush_occ", 64'(bus.occupancy), 64'd6);
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'h99;
    cyc();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    check("flush_occ",       64'(bus.occupancy), 64'd0);
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_tap_valid", 64'(bus.tap_valid), 64'd0);
    for (int c = 0; c < 15; c++) begin
      cyc();
      check("post_flush_out_valid", 64'(bus.out_valid), 64'd0);
    end

    // Reset mid-stream, then a fresh beat.
    do_reset();
    bus.advance = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus.in_valid = 1'b1; bus.in_data = 32'h700 + 32'(c);
      cyc();
    end
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    check("mrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mrst_out_data",  64'(bus.out_data),  64'd0);
    check("mrst_tap_valid", 64'(bus.tap_valid), 64'd0);
    check("mrst_tap_data",  64'(bus.tap_data),  64'd0);
    check("mrst_occ",       64'(bus.occupancy), 64'd0);
    bus.in_valid = 1'b1; bus.in_data = 32'hA5A5A5A5;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      bus.in_valid = 1'b0;
      if (c == 9) check("mrst_out_early", 64'(bus.out_valid), 64'd0);
    end
    check("mrst_new_valid", 64'(bus.out_valid), 64'd1);
    check("mrst_new_data",  64'(bus.out_data),  64'hA5A5A5A5);

    // Randomized traffic with occasional stall, flush and reset.
    for (int c = 0; c < 3000; c++) begin
      resetn       = ($urandom_range(0, 99) != 0);
      bus.in_valid = $urandom_range(0, 1) == 1;
      bus.in_data  = $urandom;
      bus.advance  = ($urandom_range(0, 3) != 0);
      bus.flush    = ($urandom_range(0, 24) == 0);
      cyc();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_delay_line.md
PIPE_DELAY_LINE -- requirements
Module: pipe_delay_line

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data bits per stage (legal 1..64).
REQ-002 SHALL have parameter DEPTH, default 10, number of register stages (legal 1..32).
REQ-003 SHALL have parameter TAP, default 5, stage index driven on tap outputs (legal 1..DEPTH).
REQ-004 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  qualifies in_data.
REQ-007 SHALL have port in_data  input  WIDTH  payload entering stage 1.
REQ-008 SHALL have port advance  input  1  1 = pipeline shifts this cycle; 0 = every stage holds.
REQ-009 SHALL have port flush  input  1  1 = invalidate all stages.
REQ-010 SHALL have port out_valid  output  1  valid bit of stage DEPTH.
REQ-011 SHALL have port out_data  output  WIDTH  data of stage DEPTH.
REQ-012 SHALL have port tap_valid  output  1  valid bit of stage TAP.
REQ-013 SHALL have port tap_data  output  WIDTH  data of stage TAP.
REQ-014 SHALL have port occupancy  output  6  count of stages whose valid bit is 1.

Function
REQ-015 SHALL hold per stage k (1..DEPTH) one WIDTH-bit data register and one valid bit.
REQ-016 With advance=1, flush=0: stage 1 SHALL load {in_valid, in_data}; stage k>1 SHALL load stage k-1.
REQ-017 Data registers SHALL shift regardless of valid; data is meaningful only where valid=1.
REQ-018 With advance=0, flush=0: all data, valid bits and occupancy SHALL hold unchanged; in_valid/in_data are dropped.
REQ-019 flush=1 SHALL clear every valid bit (including the incoming beat) and set occupancy to 0 next cycle, regardless of advance; data registers SHALL follow REQ-016/REQ-018.
REQ-020 Priority SHALL be resetn > flush > advance.
REQ-021 Latency SHALL be exactly DEPTH advance-cycles from input to out_*, TAP advance-cycles to tap_*; stalled cycles add latency 1:1.
REQ-022 All outputs SHALL be registered (no combinational path from any input to any output).
REQ-023 occupancy SHALL be a registered counter: on advance without flush, next = occ + in_valid - out_valid; width 6, no wrap possible since max = DEPTH <= 32.
REQ-024 occupancy SHALL equal the popcount of the valid bits at every clock edge.
REQ-025 DEPTH=1 SHALL degenerate to a single register stage with TAP=1 and tap outputs equal to out outputs.

Reset
REQ-026 resetn=0 at a rising edge SHALL clear all data registers, all valid bits and occupancy to 0, independent of advance/flush.
REQ-027 Reset asserted mid-stream SHALL discard all in-flight beats; the first beat accepted after release SHALL appear on out_* after DEPTH advance-cycles.
REQ-028 After reset, out_valid, out_data, tap_valid, tap_data and occupancy SHALL all read 0.

Configuration
REQ-029 Macro PIPE_DELAY_LINE_TAP_EN defined: tap_valid/tap_data SHALL be driven from stage TAP per REQ-012/REQ-013.
REQ-030 Macro PIPE_DELAY_LINE_TAP_EN undefined: tap_valid and tap_data SHALL remain as ports tied to constant 0; all other behaviour unchanged.

Verification (WIDTH=32, DEPTH=10, TAP=5, TAP_EN defined unless stated)
REQ-031 Reset then single beat in_data=0xDEADBEEF, in_valid=1, advance=1 held -> tap_valid=1 with 0xDEADBEEF exactly 5 cycles later, out_valid=1 with 0xDEADBEEF exactly 10 cycles later, each for one cycle; occupancy 1 throughout flight.
REQ-032 Continuous stream 0x1..0x14, advance=1 -> out_data 0x1..0x14 in order starting cycle 10; occupancy ramps 1..10 and holds 10.
REQ-033 Stream 0x1..0x4 then advance=0 for 3 cycles mid-flight -> all outputs and occupancy frozen during stall; 0x1 emerges at cycle 13.
REQ-034 Pipeline holding 6 valid beats, assert flush with advance=1 for one cycle -> next cycle occupancy=0, out_valid=0, tap_valid=0; no beat from before flush ever appears valid.
REQ-035 Beats in flight, drive resetn=0 for one cycle -> all outputs 0 next cycle; new beat 0xA5A5A5A5 after release appears on out_* 10 advance-cycles later; with TAP_EN undefined, tap_* stay 0 throughout all scenarios.
